// File: rtl/arbitro_destino.sv
// Output stage of the router: drains four first-word-fall-through class FIFOs and routes
// each head word to its destination FIFO. Define ARB_STRICT_PRIO_EN for fixed priority 0>1>2>3.
module arbitro_destino #(
  parameter int WORD_SIZE = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*WORD_SIZE-1:0] data_in,
  input  logic [3:0]             fifos_empty,
  input  logic [3:0]             dest_almost_full,
  output logic [3:0]             pop,
  output logic [3:0]             push,
  output logic [WORD_SIZE-1:0]   data_out,
  output logic [4:0]             cuenta_dest,
  output logic                   idle
);

  logic [3:0]           pop_q, pop_d;
  logic [3:0]           push_q, push_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic [4:0]           cuenta_q, cuenta_d;
  logic [1:0]           last_q, last_d;
  logic                 idle_q, idle_d;

  logic [WORD_SIZE-1:0] head [4];
  logic [1:0]           dest [4];
  logic [3:0]           eligible;
  logic                 found;
  logic [1:0]           gnt;
  logic [1:0]           idx;

  // A head whose pop is already in flight is stale and must not be granted again.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      head[k]     = data_in[k*WORD_SIZE +: WORD_SIZE];
      dest[k]     = head[k][WORD_SIZE-3:WORD_SIZE-4];
      eligible[k] = !fifos_empty[k] && !pop_q[k] && !dest_almost_full[dest[k]];
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    gnt   = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_STRICT_PRIO_EN
      idx = 2'(i);
`else
      idx = last_q + 2'(i + 1);
`endif
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    pop_d      = 4'b0000;
    push_d     = 4'b0000;
    data_out_d = data_out_q;
    cuenta_d   = cuenta_q;
    last_d     = last_q;
    if (found) begin
      pop_d      = 4'b0001 << gnt;
      push_d     = 4'b0001 << dest[gnt];
      data_out_d = head[gnt];
      cuenta_d   = cuenta_q + 5'd1;
`ifndef ARB_STRICT_PRIO_EN
      last_d     = gnt;
`endif
    end
    idle_d = (&fifos_empty) && (push_d == 4'b0000);
  end

  // NOTE: reset is synchronous, so it is sampled inside the clocked branch only;
  // state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q      <= 4'b0000;
      push_q     <= 4'b0000;
      data_out_q <= '0;
      cuenta_q   <= 5'd0;
      last_q     <= 2'd3;
      idle_q     <= 1'b1;
    end else begin
      pop_q      <= pop_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      cuenta_q   <= cuenta_d;
      last_q     <= last_d;
      idle_q     <= idle_d;
    end
  end

  assign pop         = pop_q;
  assign push        = push_q;
  assign data_out    = data_out_q;
  assign cuenta_dest = cuenta_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_arbitro_destino.sv
// Self-checking bench for arbitro_destino: directed steps plus random traffic, compared each
// cycle against a queue-level model of the class FIFOs and the grant rules.
module tb_arbitro_destino;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*W-1:0] data_in;
  logic [3:0]     fifos_empty;
  logic [3:0]     dest_almost_full;
  logic [3:0]     pop, push;
  logic [W-1:0]   data_out;
  logic [4:0]     cuenta_dest;
  logic           idle;

  arbitro_destino #(.WORD_SIZE(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .fifos_empty      (fifos_empty),
    .dest_almost_full (dest_almost_full),
    .pop              (pop),
    .push             (push),
    .data_out         (data_out),
    .cuenta_dest      (cuenta_dest),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  // Class FIFO contents as circular arrays with free-running read/write counts.
  logic [W-1:0] mem [4][64];
  int           rd [4];
  int           wr [4];

  logic [3:0]   m_pop, m_push;
  logic [W-1:0] m_data;
  int           m_cnt, m_last;
  logic         m_idle;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_word(input int k);
    return rd[k] != wr[k];
  endfunction

  function automatic logic [W-1:0] head_of(input int k);
    return mem[k][rd[k] % 64];
  endfunction

  task automatic put(input int k, input logic [W-1:0] w);
    mem[k][wr[k] % 64] = w;
    wr[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      fifos_empty[k]      = !has_word(k);
      data_in[k*W +: W]   = has_word(k) ? head_of(k) : W'($urandom);
    end
  endtask

  // One clock: predict the grant from queue heads, advance the model, compare all outputs.
  task automatic tick();
    int           g;
    int           k;
    logic         all_empty;
    logic [W-1:0] hw, gw;
    drive();
    g         = -1;
    gw        = '0;
    all_empty = (fifos_empty == 4'hF);
    for (int o = 0; o < 4; o++) begin
`ifdef ARB_STRICT_PRIO_EN
      k = o;
`else
      k = (m_last + 1 + o) % 4;
`endif
      hw = head_of(k);
      if (g < 0 && has_word(k) && !m_pop[k] && !dest_almost_full[hw[9:8]]) begin
        g  = k;
        gw = hw;
      end
    end
    @(posedge clk);
    for (int j = 0; j < 4; j++)
      if (m_pop[j]) rd[j]++;
    if (!reset) begin
      m_pop = 4'b0; m_push = 4'b0; m_data = '0; m_cnt = 0; m_last = 3; m_idle = 1'b1;
    end else if (g >= 0) begin
      m_pop  = 4'(1 << g);
      m_push = 4'(1 << gw[9:8]);
      m_data = gw;
      m_cnt  = (m_cnt + 1) % 32;
`ifndef ARB_STRICT_PRIO_EN
      m_last = g;
`endif
      m_idle = 1'b0;
    end else begin
      m_pop  = 4'b0;
      m_push = 4'b0;
      m_idle = all_empty;
    end
    #1;
    check("pop", 32'(pop), 32'(m_pop));
    check("push", 32'(push), 32'(m_push));
    check("data_out", 32'(data_out), 32'(m_data));
    check("cuenta_dest", 32'(cuenta_dest), 32'(m_cnt));
    check("idle", 32'(idle), 32'(m_idle));
  endtask

  function automatic bit model_empty();
    return !(has_word(0) || has_word(1) || has_word(2) || has_word(3));
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) begin rd[k] = 0; wr[k] = 0; end
    m_pop = 4'b0; m_push = 4'b0; m_data = '0; m_cnt = 0; m_last = 3; m_idle = 1'b1;
    dest_almost_full = 4'b0;
    data_in          = '0;
    fifos_empty      = 4'hF;

    // Reset held two cycles, then released with everything empty.
    reset = 1'b0;
    tick(); tick();
    check("rst_pop", 32'(pop), 32'h0);
    check("rst_push", 32'(push), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_cnt", 32'(cuenta_dest), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    reset = 1'b1;
    tick(); tick();
    check("rel_pop", 32'(pop), 32'h0);

    // Single word on FIFO0 headed for destination 2.
    put(0, 12'h2A5);
    tick();
    check("t2_pop", 32'(pop), 32'h1);
    check("t2_push", 32'(push), 32'h4);
    check("t2_data", 32'(data_out), 32'h2A5);
    check("t2_cnt", 32'(cuenta_dest), 32'h1);
    tick();
    check("t2_pop_low", 32'(pop), 32'h0);
    tick();

    // Two words in every FIFO, destination k: round-robin over all four.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 2; i++) put(k, {2'(k), 2'(k), 8'(16 * k + i)});
    for (int i = 0; i < 8; i++) begin
      tick();
`ifndef ARB_STRICT_PRIO_EN
      check("t3_order", 32'(pop), 32'(1 << (i % 4)));
`endif
    end
    tick(); tick(); tick();
    check("t3_cnt", 32'(cuenta_dest), 32'd8);
    check("t3_idle", 32'(idle), 32'h1);

    // Blocked head on FIFO1 does not hold up FIFO2.
    reset = 1'b0; tick(); reset = 1'b1;
    put(1, 12'h7C3);
    put(2, 12'h85A);
    dest_almost_full = 4'b1000;
    tick();
    check("t4_only2", 32'(pop), 32'h4);
    tick();
    check("t4_blocked", 32'(pop), 32'h0);
    dest_almost_full = 4'b0000;
    tick();
    check("t4_unblock", 32'(pop), 32'h2);
    check("t4_data", 32'(data_out), 32'h7C3);
    tick(); tick();

    // All destinations almost full: nothing is granted.
    put(3, 12'hC11);
    dest_almost_full = 4'b1111;
    tick();
    check("all_af_pop", 32'(pop), 32'h0);
    dest_almost_full = 4'b0000;
    tick(); tick();

    // 32 pushes alternating between two FIFOs to the same destination wrap the counter.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put(0, {2'd0, 2'd1, 8'(i)});
      put(1, {2'd1, 2'd1, 8'(i + 100)});
    end
    for (int i = 0; i < 40; i++) tick();
    check("t5_wrap", 32'(cuenta_dest), 32'd0);
    check("t5_idle", 32'(idle), 32'h1);

    // FIFOs 0 and 3 both busy: FIFO0 whenever eligible, FIFO3 in its stale cycles.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(0, {2'd0, 2'd3, 8'(i)});
      put(3, {2'd3, 2'd0, 8'(i)});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_alt", 32'(pop), (i % 2 == 0) ? 32'h1 : 32'h8);
    end
    tick(); tick();

    // Reset mid-transfer clears pop/push; the FIFO contents survive.
    put(2, 12'hA2F);
    put(2, 12'hA30);
    tick();
    reset = 1'b0;
    tick();
    check("midrst_pop", 32'(pop), 32'h0);
    check("midrst_push", 32'(push), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic, backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 2) == 0 && (wr[k] - rd[k]) < 60)
          put(k, {2'(k), 2'($urandom), 8'($urandom)});
      dest_almost_full = 4'($urandom) & 4'($urandom);
      reset            = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset            = 1'b1;
    dest_almost_full = 4'b0;
    for (int i = 0; i < 600 && !(model_empty() && m_idle); i++) tick();
    tick();
    check("drain_idle", 32'(idle), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
